spin_job_sequencer: RTL and testbench



---
 rtl/spin_pkg.sv | 30 +++
 rtl/spin_job_sequencer.sv | 151 +++++++++++++++
 tb/tb_spin_job_sequencer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spin_pkg.sv
// -----------------------------------------------------------------------------
// spin_pkg
// Shared types and helpers for the spinner job sequencer.
//   word_t  : 32-bit data word handled by the spinner
//   amt_t   : 5-bit right-rotate amount
//   state_t : sequencer FSM states
//   rotr()  : right rotate, used by the optional self-check (SPIN_CHECK_EN)
// -----------------------------------------------------------------------------
package spin_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [4:0]        amt_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ROT  = 3'd2,
        GAP  = 3'd3,
        CAPT = 3'd4,
        HOLD = 3'd5
    } state_t;

    // A shift by 32 yields zero, so amount 0 returns d unchanged.
    function automatic word_t rotr(input word_t d, input amt_t a);
        return (d >> a) | (d << (6'd32 - {1'b0, a}));
    endfunction

endpackage

// File: rtl/spin_job_sequencer.sv
// -----------------------------------------------------------------------------
// spin_job_sequencer
// Command stage in front of the 32-bit spinner (rotate-right barrel stage with
// registered input, registered output and a registered spin feedback flag).
// Takes one rotate job {data, amount, repeat count N} at a time, chains N
// rotations through the spinner feedback loop (two cycles per pass) and
// returns the final word on a valid/ready result port.
//
// Ports:
//   clock, reset              single clock, synchronous active-high reset
//   job_valid/job_ready       job handshake (ready only while idle)
//   job_data/amount/rep       word, per-pass rotate amount, pass count N
//   res_valid/res_ready       result handshake, result held until accepted
//   res_data                  rotated word
//   sp_din/sp_spin/sp_amount  drive pins of the spinner
//   sp_dout                   spinner output
//   res_err                   self-check mismatch flag
//
// Build option: define SPIN_CHECK_EN to latch a reference result at accept
// and compare it against the spinner output at capture time. Without it
// res_err is tied low and no reference logic exists.
// -----------------------------------------------------------------------------
module spin_job_sequencer
    import spin_pkg::*;
#(
    parameter int REP_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [31:0]      job_data,
    input  logic [4:0]       job_amount,
    input  logic [REP_W-1:0] job_rep,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [31:0]      sp_din,
    output logic             sp_spin,
    output logic [4:0]       sp_amount,
    input  logic [31:0]      sp_dout,
    output logic             res_err
);

    state_t           state, state_nxt;
    word_t            d_q;
    amt_t             a_q;
    logic [REP_W-1:0] n_q;
    logic [REP_W-1:0] k_q;
    logic             accept;
    amt_t             a_eff;
    logic [REP_W-1:0] n_eff;

    // N=0 runs as a single pass with a zero amount, so the word comes back as is.
    assign a_eff = (job_rep == '0) ? '0 : job_amount;
    assign n_eff = (job_rep == '0) ? REP_W'(1) : job_rep;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            k_q      <= '0;
            res_data <= '0;
        end else begin
            state <= state_nxt;
            if (state == LOAD)
                k_q <= REP_W'(1);
            else if (state == GAP)
                k_q <= k_q + REP_W'(1);
            if (state == CAPT)
                res_data <= sp_dout;
        end
    end

    // Job operands only matter after an accept, so they carry no reset.
    always_ff @(posedge clock) begin
        if (accept) begin
            d_q <= job_data;
            a_q <= a_eff;
            n_q <= n_eff;
        end
    end

    // Spinner pins depend only on state and latched job registers.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        job_ready = 1'b0;
        res_valid = 1'b0;
        sp_din    = '0;
        sp_spin   = 1'b0;
        sp_amount = '0;
        unique case (state)
            IDLE: begin
                job_ready = 1'b1;
                if (job_valid) begin
                    accept    = 1'b1;
                    state_nxt = LOAD;
                end
            end
            // spin was low in IDLE, so the spinner takes din at this edge.
            LOAD: begin
                sp_din    = d_q;
                state_nxt = ROT;
            end
            // Raising spin here makes the spinner feed dout back to its input
            // at the end of the following GAP cycle.
            ROT: begin
                sp_amount = a_q;
                sp_spin   = (k_q < n_q);
                state_nxt = (k_q < n_q) ? GAP : CAPT;
            end
            GAP: begin
                state_nxt = ROT;
            end
            CAPT: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                res_valid = 1'b1;
                if (res_ready)
                    state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef SPIN_CHECK_EN
    word_t ref_q;
    logic  err_q;

    // Only the low five bits of A*N matter for a 32-bit rotate.
    always_ff @(posedge clock) begin
        if (accept)
            ref_q <= rotr(job_data, amt_t'(a_eff * n_eff));
    end

    always_ff @(posedge clock) begin
        if (reset)
            err_q <= 1'b0;
        else if (state == CAPT)
            err_q <= (sp_dout != ref_q);
    end

    assign res_err = err_q;
`else
    assign res_err = 1'b0;
`endif

endmodule

// File: tb/tb_spin_job_sequencer.sv
// -----------------------------------------------------------------------------
// tb_spin_job_sequencer
// Directed bench for spin_job_sequencer with a behavioural spinner attached.
// Expected results are queued when a job is accepted and compared when the
// result is handed over.
// -----------------------------------------------------------------------------
module tb_spin_job_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        job_valid;
    logic        job_ready;
    logic [31:0] job_data;
    logic [4:0]  job_amount;
    logic [3:0]  job_rep;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [31:0] sp_din;
    logic        sp_spin;
    logic [4:0]  sp_amount;
    logic [31:0] sp_dout;
    logic        res_err;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    logic [31:0] exp_q[$];

    always #5 clock = ~clock;

    spin_job_sequencer #(.REP_W(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .job_valid  (job_valid),
        .job_ready  (job_ready),
        .job_data   (job_data),
        .job_amount (job_amount),
        .job_rep    (job_rep),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .sp_din     (sp_din),
        .sp_spin    (sp_spin),
        .sp_amount  (sp_amount),
        .sp_dout    (sp_dout),
        .res_err    (res_err)
    );

    // Rotate one bit at a time: independent of the design's helper.
    function automatic logic [31:0] tb_rotr(input logic [31:0] d, input int s);
        logic [31:0] r;
        r = d;
        for (int i = 0; i < s; i++)
            r = {r[0], r[31:1]};
        return r;
    endfunction

    function automatic logic [31:0] job_expect(input logic [31:0] d, input int a, input int n);
        int ne;
        int ae;
        ne = (n == 0) ? 1 : n;
        ae = (n == 0) ? 0 : a;
        return tb_rotr(d, (ae * ne) % 32);
    endfunction

    // Spinner model: inr <= spl ? dout : din; dout <= rotr(inr, amount); spl <= spin.
    logic [31:0] m_inr  = 32'h0;
    logic [31:0] m_dout = 32'h0;
    logic        m_spl  = 1'b0;
    logic        flip   = 1'b0;

    always @(posedge clock) begin
        m_inr  <= m_spl ? m_dout : sp_din;
        m_dout <= tb_rotr(m_inr, int'(sp_amount));
        m_spl  <= sp_spin;
    end

    assign sp_dout = m_dout ^ {31'b0, flip};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offer a job, wait (bounded) until it is accepted, queue its expectation.
    task automatic start_job(input logic [31:0] d, input logic [4:0] a,
                             input logic [3:0] n, input logic [31:0] exp);
        int t;
        job_data   = d;
        job_amount = a;
        job_rep    = n;
        job_valid  = 1'b1;
        t = 0;
        while (!job_ready && t < 100) begin
            tick();
            t++;
        end
        check("job_ready_before_accept", {31'b0, job_ready}, 32'd1);
        tick();
        job_valid = 1'b0;
        exp_q.push_back(exp);
    endtask

    // Edges are counted with the accept edge as the first one.
    task automatic wait_result(input int neff, input bit chk_first);
        int edges;
        int pulses;
        int first;
        edges  = 1;
        pulses = 0;
        first  = 0;
        for (int t = 0; t < 100; t++) begin
            tick();
            edges++;
            if (sp_spin) begin
                pulses++;
                if (first == 0)
                    first = edges;
            end
            if (res_valid)
                break;
        end
        check("latency_edges", edges, 2 * neff + 2);
        check("spin_pulses", pulses, neff - 1);
        if (chk_first)
            check("first_spin_edge", first, 2);
    endtask

    task automatic drain(input int hold);
        logic [31:0] e;
        e = (exp_q.size() > 0) ? exp_q[0] : 32'hXXXXXXXX;
        res_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", {31'b0, res_valid}, 32'd1);
            check("hold_data", res_data, e);
            check("hold_job_ready", {31'b0, job_ready}, 32'd0);
            check("hold_spin", {31'b0, sp_spin}, 32'd0);
        end
        check("sb_not_empty", exp_q.size(), (exp_q.size() > 0) ? exp_q.size() : 1);
        if (exp_q.size() > 0)
            e = exp_q.pop_front();
        check("res_valid_at_xfer", {31'b0, res_valid}, 32'd1);
        check("res_data", res_data, e);
        check("res_err", {31'b0, res_err}, 32'd0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("res_valid_after_xfer", {31'b0, res_valid}, 32'd0);
        check("job_ready_after_xfer", {31'b0, job_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        job_valid  = 1'b0;
        job_data   = '0;
        job_amount = '0;
        job_rep    = '0;
        res_ready  = 1'b0;
        repeat (3) tick();

        check("rst_res_valid", {31'b0, res_valid}, 32'd0);
        check("rst_res_data", res_data, 32'h0);
        check("rst_res_err", {31'b0, res_err}, 32'd0);
        check("rst_sp_din", sp_din, 32'h0);
        check("rst_sp_spin", {31'b0, sp_spin}, 32'd0);
        check("rst_sp_amount", {27'b0, sp_amount}, 32'd0);
        check("rst_job_ready", {31'b0, job_ready}, 32'd1);
        reset = 1'b0;
        tick();

        // Single pass
        start_job(32'h00000001, 5'd1, 4'd1, 32'h80000000);
        wait_result(1, 1'b0);
        drain(0);

        // Two passes, spin raised only in the first ROT cycle
        start_job(32'h12345678, 5'd4, 4'd2, 32'h78123456);
        wait_result(2, 1'b1);
        drain(0);

        // N=0 passes the word through
        start_job(32'hDEADBEEF, 5'd7, 4'd0, 32'hDEADBEEF);
        wait_result(1, 1'b0);
        drain(0);

        // Maximum repeat count, 31*15 mod 32 = 17
        start_job(32'h00000001, 5'd31, 4'd15, 32'h00008000);
        wait_result(15, 1'b1);
        drain(0);

        // Backpressure with a new job offered during HOLD
        start_job(32'hCAFEF00D, 5'd9, 4'd3, job_expect(32'hCAFEF00D, 9, 3));
        wait_result(3, 1'b1);
        job_data   = 32'h0BADC0DE;
        job_amount = 5'd13;
        job_rep    = 4'd2;
        job_valid  = 1'b1;
        drain(5);
        start_job(32'h0BADC0DE, 5'd13, 4'd2, job_expect(32'h0BADC0DE, 13, 2));
        wait_result(2, 1'b1);
        drain(0);

        // Reset during the third ROT of an N=5 job
        start_job(32'hA5A5A5A5, 5'd3, 4'd5, job_expect(32'hA5A5A5A5, 3, 5));
        repeat (5) tick();
        check("rot3_spin", {31'b0, sp_spin}, 32'd1);
        check("rot3_amount", {27'b0, sp_amount}, 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        void'(exp_q.pop_back());
        check("midrst_job_ready", {31'b0, job_ready}, 32'd1);
        check("midrst_res_valid", {31'b0, res_valid}, 32'd0);
        check("midrst_sp_spin", {31'b0, sp_spin}, 32'd0);
        start_job(32'hF0000000, 5'd4, 4'd1, 32'h0F000000);
        wait_result(1, 1'b0);
        drain(0);

        // A few more patterns
        for (int j = 0; j < 4; j++) begin
            logic [31:0] d;
            logic [4:0]  a;
            logic [3:0]  n;
            d = $urandom();
            a = 5'($urandom_range(0, 31));
            n = 4'($urandom_range(0, 6));
            start_job(d, a, n, job_expect(d, int'(a), int'(n)));
            wait_result((n == 0) ? 1 : int'(n), 1'b0);
            drain(j);
        end

`ifdef SPIN_CHECK_EN
        // Corrupt sp_dout bit 0 during CAPT of an N=1 job
        start_job(32'h13579BDF, 5'd2, 4'd1, tb_rotr(32'h13579BDF, 2) ^ 32'h1);
        tick();
        tick();
        flip = 1'b1;
        tick();
        flip = 1'b0;
        check("chk_res_valid", {31'b0, res_valid}, 32'd1);
        check("chk_res_err", {31'b0, res_err}, 32'd1);
        check("chk_res_data", res_data, exp_q.pop_front());
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("chk_job_ready", {31'b0, job_ready}, 32'd1);
`endif

        check("sb_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
